// File: rtl/imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// imem_fetch_responder
//
// Purpose
//   Responder side of the F2 instruction-fetch port. For the byte address on
//   iaddr_i it serves a 64-bit instruction pair {inst@W, inst@W+1}, where
//   W = iaddr_i[AW-1:2]. The pair is filled from a 32-bit word memory over a
//   req/ack handshake, two words per fill. stall_o stays high until the pair
//   for the current address is held in the output buffer.
//
// Optional feature (compile-time macro IMEM_PAIR_REUSE_EN)
//   When defined, a miss on word tag+1 reuses the buffered second word as the
//   new first word. Only the missing word is fetched, so the miss costs 2 stall
//   cycles instead of 3. When undefined, every miss fetches both words.
//
// Parameters
//   AW        fetch byte-address width; word addresses are AW-2 bits
//   FILL_MAX  words per fill; only 2 is supported (checked at elaboration)
//
// Ports
//   clock_i      in   1     single clock, rising edge
//   reset_n_i    in   1     asynchronous assert, active-low reset
//   iaddr_i      in   AW    fetch byte address; bits [1:0] are ignored
//   idata_o      out  64    [63:32] = inst@W, [31:0] = inst@W+1
//   stall_o      out  1     high until idata_o is valid for iaddr_i
//   mem_req_o    out  1     word-memory request (registered)
//   mem_addr_o   out  AW-2  word address of the request (registered)
//   mem_rdata_i  in   32    read data, valid while mem_ack_i is high
//   mem_ack_i    in   1     request completion; same-cycle ack allowed
// -----------------------------------------------------------------------------
module imem_fetch_responder #(
    parameter int AW       = 10,
    parameter int FILL_MAX = 2
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic [AW-1:0] iaddr_i,
    output logic [63:0]   idata_o,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic [AW-3:0] mem_addr_o,
    input  logic [31:0]   mem_rdata_i,
    input  logic          mem_ack_i
);

    localparam int WAW = AW - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH0 = 2'd1,
        ST_FETCH1 = 2'd2
    } state_t;

    // The pair buffer is organised as two 32-bit halves; anything other than
    // two words per fill would break the {inst@W, inst@W+1} layout.
    generate
        if (FILL_MAX != 2) begin : g_fill_max_check
            $error("imem_fetch_responder supports FILL_MAX == 2 only");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t                       r_state;
    logic                         r_valid;
    logic [WAW-1:0]               r_tag;
    logic [WAW-1:0]               r_fa;
    logic                         r_req;
    logic [WAW-1:0]               r_addr;
    logic [FILL_MAX-1:0][31:0]    r_half;

    state_t                       w_state_next;
    logic                         w_valid_next;
    logic [WAW-1:0]               w_tag_next;
    logic [WAW-1:0]               w_fa_next;
    logic                         w_req_next;
    logic [WAW-1:0]               w_addr_next;
    logic [FILL_MAX-1:0][31:0]    w_half_next;

    // -------------------------------------------------------------------------
    // Address decode and hit detection
    // -------------------------------------------------------------------------
    logic [WAW-1:0] w_word;
    logic           w_hit;
    logic           w_unused_byte_bits;
    logic           w_ack_fill;
    logic           w_fill_second;
    logic           w_reuse_take;

    assign w_word             = iaddr_i[AW-1:2];
    assign w_unused_byte_bits = ^iaddr_i[1:0];
    assign w_hit              = r_valid && (r_tag == w_word);

    // Data is only ever presented for a matching tag while no fill is running.
    assign stall_o    = !(w_hit && (r_state == ST_IDLE));

    // An ack only means something while a request is actually outstanding;
    // stray acks in IDLE (e.g. right after reset) are dropped here.
    assign w_ack_fill    = mem_ack_i && r_req && (r_state != ST_IDLE);
    assign w_fill_second = (r_state == ST_FETCH1);

`ifdef IMEM_PAIR_REUSE_EN
    logic [WAW-1:0] w_tag_inc;
    assign w_tag_inc = r_tag + WAW'(1);
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_tag_next   = r_tag;
        w_fa_next    = r_fa;
        w_req_next   = r_req;
        w_addr_next  = r_addr;
        w_reuse_take = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_hit) begin
                    // The buffer is about to be overwritten, so it must not be
                    // reported valid until the new fill has completed.
                    w_valid_next = 1'b0;
                    w_req_next   = 1'b1;
`ifdef IMEM_PAIR_REUSE_EN
                    if (r_valid && (w_word == w_tag_inc)) begin
                        // Sequential step: the buffered second word is the new
                        // first word, only word tag+2 has to come from memory.
                        w_reuse_take = 1'b1;
                        w_fa_next    = w_tag_inc;
                        w_addr_next  = w_tag_inc + WAW'(1);
                        w_state_next = ST_FETCH1;
                    end else
`endif
                    begin
                        w_fa_next    = w_word;
                        w_addr_next  = w_word;
                        w_state_next = ST_FETCH0;
                    end
                end
            end

            ST_FETCH0: begin
                if (w_ack_fill) begin
                    // Keep the request up and move straight to the next word;
                    // the address wraps naturally at the word-address width.
                    w_addr_next  = r_fa + WAW'(1);
                    w_state_next = ST_FETCH1;
                end
            end

            ST_FETCH1: begin
                if (w_ack_fill) begin
                    w_req_next   = 1'b0;
                    w_tag_next   = r_fa;
                    w_valid_next = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_req_next   = 1'b0;
                w_valid_next = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pair buffer update: half 0 holds inst@W, half 1 holds inst@W+1. Each
    // half only changes on its own ack capture (or the reuse copy).
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < FILL_MAX; gi++) begin : g_half
            if (gi == 0) begin : g_upper
                assign w_half_next[gi] = w_reuse_take                  ? r_half[FILL_MAX-1] :
                                         (w_ack_fill && !w_fill_second) ? mem_rdata_i        :
                                                                          r_half[gi];
            end else begin : g_lower
                assign w_half_next[gi] = (w_ack_fill && w_fill_second) ? mem_rdata_i :
                                                                         r_half[gi];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Registers: reset asserts asynchronously so an in-flight request drops
    // in the same cycle reset arrives.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_fa    <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_half  <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_tag   <= w_tag_next;
            r_fa    <= w_fa_next;
            r_req   <= w_req_next;
            r_addr  <= w_addr_next;
            r_half  <= w_half_next;
        end
    end

    assign mem_req_o  = r_req;
    assign mem_addr_o = r_addr;
    assign idata_o    = {r_half[0], r_half[FILL_MAX-1]};

endmodule

// File: tb/tb_imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_responder
//
// Drives fetch addresses into imem_fetch_responder against a word memory that
// holds M[w] = 0x1000 + w and acks after a chosen (or random) number of wait
// cycles. Expected request addresses and expected pair/stall results are
// pushed into queues when a fetch is issued; monitor processes pop and compare
// whenever the DUT hands a request to memory or drops stall.
// -----------------------------------------------------------------------------
module tb_imem_fetch_responder;

`ifdef IMEM_PAIR_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic        clock_i   = 1'b0;
    logic        reset_n_i = 1'b1;
    logic [9:0]  iaddr_i   = 10'h010;
    logic [63:0] idata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_ack_i   = 1'b0;

    imem_fetch_responder #(.AW(10), .FILL_MAX(2)) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .iaddr_i     (iaddr_i),
        .idata_o     (idata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clock_i = ~clock_i;

    // ---------------- reference model ----------------
    function automatic logic [31:0] mem_word(input logic [7:0] w);
        return 32'h1000 + {24'h0, w};
    endfunction

    function automatic logic [63:0] pair(input logic [7:0] w);
        logic [7:0] n;
        n = w + 8'd1;
        return {mem_word(w), mem_word(n)};
    endfunction

    typedef struct {
        logic [63:0] data;
        int          fixed;   // >=0: exact stall count; -1: base + memory waits
        int          base;
        int          id;
        logic [9:0]  addr;
    } txn_t;

    txn_t       txn_q[$];
    logic [7:0] req_q[$];
    bit         m_valid     = 1'b0;
    logic [7:0] m_tag       = 8'h00;
    bit         hold_chk_en = 1'b0;
    int         txn_no      = 0;
    int         n_checks    = 0;
    int         n_fail      = 0;

    // memory model controls
    int cfg_delay  = 0;
    bit rand_delay = 1'b0;
    bit ack_force  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Issue a fetch and record what the specification says must follow.
    task automatic issue(input logic [9:0] a, input int fixed);
        logic [7:0] w;
        txn_t       t;
        w       = a[9:2];
        iaddr_i = a;
        if (m_valid && m_tag == w) begin
            t.base = 0;
        end else if (REUSE && m_valid && w == m_tag + 8'd1) begin
            req_q.push_back(w + 8'd1);
            t.base = 2;
        end else begin
            req_q.push_back(w);
            req_q.push_back(w + 8'd1);
            t.base = 3;
        end
        m_valid = 1'b1;
        m_tag   = w;
        t.data  = pair(w);
        t.fixed = fixed;
        t.id    = txn_no;
        t.addr  = a;
        txn_no++;
        txn_q.push_back(t);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (txn_q.size() != 0 && k < 200) begin
            @(posedge clock_i);
            #1;
            k++;
        end
        if (txn_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: got stall still high after %0d cycles, required completion", k);
            finish_test();
        end
    endtask

    task automatic cycles(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    // ---------------- word memory (evaluated on the falling edge) -----------
    initial begin : mem_model
        int  wait_left;
        bit  armed;
        wait_left = 0;
        armed     = 1'b0;
        forever begin
            @(negedge clock_i);
            mem_rdata_i = mem_word(mem_addr_o);
            if (!mem_req_o) begin
                armed     = 1'b0;
                mem_ack_i = ack_force;
            end else begin
                if (!armed) begin
                    wait_left = rand_delay ? int'($urandom_range(0, 3)) : cfg_delay;
                    armed     = 1'b1;
                end
                if (wait_left == 0) begin
                    mem_ack_i = 1'b1;
                    armed     = 1'b0;
                end else begin
                    mem_ack_i = ack_force;
                    wait_left--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        int          st_cnt;
        int          wt_cnt;
        int          exp_st;
        txn_t        t;
        logic [7:0]  exp_a;
        bit          prv_rst, prv_req, prv_ack, prv_stall, chg_ok;
        logic [7:0]  prv_addr;
        logic [63:0] prv_idata;
        st_cnt  = 0;
        wt_cnt  = 0;
        prv_rst = 1'b0;
        prv_req = 1'b0;
        prv_ack = 1'b0;
        prv_stall = 1'b1;
        prv_addr  = 8'h0;
        prv_idata = 64'h0;
        forever begin
            @(negedge clock_i);
            #1;
            if (!reset_n_i) begin
                st_cnt = 0;
                wt_cnt = 0;
            end else begin
                if (mem_req_o && mem_ack_i) begin
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: got addr 0x%02h, required no request", mem_addr_o);
                    end else begin
                        exp_a = req_q.pop_front();
                        check("req_addr", {56'h0, mem_addr_o}, {56'h0, exp_a});
                    end
                end
                if (prv_rst && prv_req && !prv_ack) begin
                    check("req_held", {63'h0, mem_req_o}, 64'h1);
                    check("addr_held", {56'h0, mem_addr_o}, {56'h0, prv_addr});
                end
                if (prv_rst) begin
                    chg_ok = (prv_req && prv_ack) || (REUSE && prv_stall && !prv_req);
                    if (!chg_ok) check("idata_stable", idata_o, prv_idata);
                end
                if (txn_q.size() != 0) begin
                    if (stall_o) begin
                        st_cnt++;
                        if (mem_req_o && !mem_ack_i) wt_cnt++;
                    end else begin
                        t      = txn_q.pop_front();
                        exp_st = (t.fixed >= 0) ? t.fixed : t.base + wt_cnt;
                        check("pair_data", idata_o, t.data);
                        check("stall_cycles", 64'(st_cnt), 64'(exp_st));
                        $display("txn %0d: iaddr=0x%03h idata=0x%016h stall_cycles=%0d",
                                 t.id, t.addr, idata_o, st_cnt);
                        st_cnt = 0;
                        wt_cnt = 0;
                    end
                end else if (hold_chk_en) begin
                    check("hold_stall", {63'h0, stall_o}, 64'h0);
                    check("hold_req", {63'h0, mem_req_o}, 64'h0);
                    check("hold_data", idata_o, pair(m_tag));
                end
            end
            prv_rst   = reset_n_i;
            prv_req   = mem_req_o;
            prv_ack   = mem_ack_i;
            prv_stall = stall_o;
            prv_addr  = mem_addr_o;
            prv_idata = idata_o;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int         sel;
        logic [7:0] w;
        #1 reset_n_i = 1'b0;
        #2;
        check("rst_stall", {63'h0, stall_o}, 64'h1);
        check("rst_req", {63'h0, mem_req_o}, 64'h0);
        check("rst_addr", {56'h0, mem_addr_o}, 64'h0);
        check("rst_idata", idata_o, 64'h0);
        cycles(3);

        // 1: cold miss on 0x010, zero-wait memory
        reset_n_i = 1'b1;
        issue(10'h010, 3);
        wait_done();
        hold_chk_en = 1'b1;

        // 2: hold the address
        cycles(10);

        // 3: word-address wrap
        issue(10'h3FC, 3);
        wait_done();

        // 4: two wait cycles per request
        cfg_delay = 2;
        issue(10'h020, 7);
        wait_done();
        cfg_delay = 0;

        // 5: sequential step 0x010 -> 0x014
        issue(10'h010, 3);
        wait_done();
        issue(10'h014, REUSE ? 2 : 3);
        wait_done();

        // 6a: address changes to 0x040 during FETCH1 of 0x010
        begin
            txn_t t;
            iaddr_i = 10'h010;
            req_q.push_back(8'h04);
            req_q.push_back(8'h05);
            req_q.push_back(8'h10);
            req_q.push_back(8'h11);
            t.data  = pair(8'h10);
            t.fixed = 6;
            t.base  = 0;
            t.id    = txn_no;
            t.addr  = 10'h040;
            txn_no++;
            txn_q.push_back(t);
            m_tag   = 8'h10;
            m_valid = 1'b1;
        end
        cycles(2);
        iaddr_i = 10'h040;
        wait_done();

        // 6b: reset while a request is waiting on memory
        hold_chk_en = 1'b0;
        cfg_delay   = 5;
        iaddr_i     = 10'h100;
        cycles(2);
        check("prerst_req", {63'h0, mem_req_o}, 64'h1);
        reset_n_i = 1'b0;
        #1;
        check("midrst_req", {63'h0, mem_req_o}, 64'h0);
        check("midrst_idata", idata_o, 64'h0);
        check("midrst_stall", {63'h0, stall_o}, 64'h1);
        cfg_delay = 0;
        cycles(1);
        m_valid   = 1'b0;
        reset_n_i = 1'b1;
        ack_force = 1'b1;
        issue(10'h100, 3);
        cycles(1);
        ack_force = 1'b0;
        check("stray_ack_ignored", idata_o, 64'h0);
        wait_done();
        hold_chk_en = 1'b1;

        // Randomised traffic: hits, sequential steps and random jumps with
        // random memory wait states and random hold periods.
        rand_delay = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       w = m_tag;
                1:       w = m_tag + 8'd1;
                default: w = 8'($urandom);
            endcase
            issue({w, 2'($urandom)}, -1);
            wait_done();
            cycles(int'($urandom_range(0, 3)));
        end
        rand_delay = 1'b0;

        cycles(2);
        check("req_queue_drained", 64'(req_q.size()), 64'h0);
        finish_test();
    end

endmodule
